// File: rtl/chip8_sprite_draw.sv
// CHIP-8 DXYN sprite engine: fetches sprite rows from main memory and XORs them
// into the 64x32 framebuffer one byte (or two when straddling) per row.
module chip8_sprite_draw #(
  parameter int MEM_AW = 12,
  parameter int FB_AW  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        x,
  input  logic [7:0]        y,
  input  logic [3:0]        n,
  input  logic [MEM_AW-1:0] sprite_addr,
  output logic              busy,
  output logic              done,
  output logic              collision,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [FB_AW-1:0]  fb_addr,
  input  logic [7:0]        fb_rdata,
  output logic [7:0]        fb_wdata,
  output logic              fb_we
);

  typedef enum logic [2:0] {IDLE, MEM, FBL, WL, FBR, WR, DONE} state_t;

  state_t            state, state_nx;
  logic [5:0]        x0;
  logic [4:0]        y0;
  logic [3:0]        nrow;
  logic [MEM_AW-1:0] base;
  logic [4:0]        row;
  logic [7:0]        s;

  logic [2:0] sh;
  logic       need_right, last_row, advance, right_half, hit;
  logic [4:0] row_nx, yrow;
  logic [5:0] ypos_nx;
  logic [7:0] sl, sr;

  assign sh         = x0[2:0];
  // No horizontal wrap: a sprite starting in the last byte column loses its right part.
  assign need_right = (sh != 3'd0) && (x0[5:3] != 3'd7);
  assign row_nx     = row + 5'd1;
  assign ypos_nx    = {1'b0, y0} + {1'b0, row_nx};
  assign last_row   = (row_nx == {1'b0, nrow}) || (ypos_nx == 6'd32);
  assign advance    = ((state == WL) && !need_right) || (state == WR);
  assign right_half = (state == FBR) || (state == WR);
  assign yrow       = y0 + row;
  assign sl         = s >> sh;
  assign sr         = s << (4'd8 - {1'b0, sh});

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign fb_we    = (state == WL) || (state == WR);
  assign mem_addr = base + MEM_AW'(row);
  assign fb_addr  = FB_AW'({yrow, x0[5:3]}) + FB_AW'(right_half);

  always_comb begin
    fb_wdata = 8'h00;
    hit      = 1'b0;
    if (state == WL) begin
      fb_wdata = fb_rdata ^ sl;
      hit      = |(fb_rdata & sl);
    end else if (state == WR) begin
      fb_wdata = fb_rdata ^ sr;
      hit      = |(fb_rdata & sr);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (n == 4'd0) ? DONE : MEM;
      MEM:  state_nx = FBL;
      FBL:  state_nx = WL;
      WL:   state_nx = need_right ? FBR : (last_row ? DONE : MEM);
      FBR:  state_nx = WR;
      WR:   state_nx = last_row ? DONE : MEM;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x0        <= '0;
      y0        <= '0;
      nrow      <= '0;
      base      <= '0;
      row       <= '0;
      s         <= '0;
      collision <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        x0        <= x[5:0];
        y0        <= y[4:0];
        nrow      <= n;
        base      <= sprite_addr;
        row       <= '0;
        collision <= 1'b0;
      end
      if (state == FBL) s <= mem_rdata;
      if (fb_we) collision <= collision | hit;
      if (advance) row <= row_nx;
    end
  end

endmodule
